// File: rtl/status_frame_reader_pkg.sv
// Shared constants for the status frame reader.
// Header default, frame overhead, FSM encodings, word type.
package status_frame_reader_pkg;

   localparam logic [15:0] HDR_WORD_DEF = 16'hEB90;
   localparam int          FRAME_OVH    = 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_PAY  = 2'd2;
   localparam logic [1:0] ST_CSUM = 2'd3;

   typedef logic [63:0] word_t;

endpackage

// File: rtl/status_frame_reader_if.sv
// Byte stream towards the upload packer.
// master: tx_data/tx_valid/tx_last out, tx_ready in.
interface status_frame_reader_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      output tx_last,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  tx_last,
      output tx_ready
   );

endinterface

// File: rtl/status_frame_reader_fifo.sv
// status_word_fifo: sync 64-bit FIFO, DEPTH entries.
// Ports: push/wdata, pop/rdata (show-ahead), count, empty, full.
module status_word_fifo
   import status_frame_reader_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   sys_clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  word_t                  wdata,
   input  logic                   pop,
   output word_t                  rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

   word_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/status_frame_reader.sv
// Reads WORD_CNT status words, streams hdr|seq|payload|csum bytes.
// Ports: req/busy, RAM read port, tx byte stream (if), frame_cnt.
module status_frame_reader
   import status_frame_reader_pkg::*;
#(
   parameter int          WORD_CNT   = 128,
   parameter logic [15:0] HDR_WORD   = HDR_WORD_DEF,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                         sys_clk,
   input  logic                         rst_n,
   input  logic                         req,
   output logic                         busy,
   output logic [6:0]                   status_ram_addr,
   output logic                         status_ram_rd_en,
   input  word_t                        status_ram_data,
   input  logic                         status_ram_data_vld,
   status_frame_reader_if.master        tx,
   output logic [15:0]                  frame_cnt
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [7:0] WCNT   = WORD_CNT[7:0];
   localparam logic [CW:0] CREDIT = FIFO_DEPTH[CW:0];

   logic [1:0]    state;
   logic [1:0]    hdr_idx;
   logic          req_hold;
   logic [7:0]    rd_cnt;
   logic [7:0]    pop_cnt;
   logic [CW-1:0] out_cnt;
   logic [63:0]   sr;
   logic [3:0]    sr_cnt;
   logic [7:0]    csum;
   logic [15:0]   frame_cnt_q;
   logic [7:0]    hdr_byte;

   word_t         fifo_rdata;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_empty;
   logic          fifo_full;
   logic          fifo_push;
   logic          fifo_pop;

   logic start;
   logic fire;
   logic pay_fire;
   logic last_pay;
   logic fetching;
   logic rd_en;

   status_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .push    (fifo_push),
      .wdata   (status_ram_data),
      .pop     (fifo_pop),
      .rdata   (fifo_rdata),
      .count   (fifo_cnt),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // req_hold blocks the cycle right after the last byte.
   assign start    = req && (state == ST_IDLE) && !req_hold;
   assign fire     = tx.tx_valid && tx.tx_ready;
   assign pay_fire = fire && (state == ST_PAY);
   assign fetching = (state == ST_HDR) || (state == ST_PAY);

   // Credit: in-flight reads plus stored words never exceed depth.
   assign rd_en = fetching && (rd_cnt < WCNT) && !fifo_full &&
                  (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < CREDIT);

   // Stray data_vld with nothing in flight is dropped.
   assign fifo_push = status_ram_data_vld && (out_cnt != '0);
   assign fifo_pop  = fetching && !fifo_empty &&
                      ((sr_cnt == 4'd0) ||
                       ((sr_cnt == 4'd1) && pay_fire));
   assign last_pay  = pay_fire && (sr_cnt == 4'd1) &&
                      (pop_cnt == WCNT);

   assign busy             = (state != ST_IDLE);
   assign status_ram_rd_en = rd_en;
   assign status_ram_addr  = rd_cnt[6:0];
   assign frame_cnt        = frame_cnt_q;

   always_comb begin
      hdr_byte = HDR_WORD[15:8];
      unique case (hdr_idx)
         2'd1:    hdr_byte = HDR_WORD[7:0];
         2'd2:    hdr_byte = frame_cnt_q[15:8];
         2'd3:    hdr_byte = frame_cnt_q[7:0];
         default: ;
      endcase
   end

   always_comb begin
      tx.tx_data  = 8'h00;
      tx.tx_valid = 1'b0;
      tx.tx_last  = 1'b0;
      unique case (1'b1)
         state == ST_HDR: begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = hdr_byte;
         end
         state == ST_PAY: begin
            tx.tx_valid = (sr_cnt != 4'd0);
            tx.tx_data  = sr[63:56];
         end
         state == ST_CSUM: begin
            tx.tx_valid = 1'b1;
            tx.tx_last  = 1'b1;
            tx.tx_data  = csum;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         hdr_idx     <= 2'd0;
         req_hold    <= 1'b0;
         rd_cnt      <= 8'd0;
         pop_cnt     <= 8'd0;
         out_cnt     <= '0;
         sr          <= 64'd0;
         sr_cnt      <= 4'd0;
         csum        <= 8'd0;
         frame_cnt_q <= 16'd0;
      end else begin
         req_hold <= 1'b0;
         unique case (state)
            ST_IDLE: if (start) begin
               state   <= ST_HDR;
               hdr_idx <= 2'd0;
               rd_cnt  <= 8'd0;
               pop_cnt <= 8'd0;
               csum    <= 8'd0;
            end
            ST_HDR: if (fire) begin
               hdr_idx <= hdr_idx + 2'd1;
               if (hdr_idx == 2'd3) state <= ST_PAY;
            end
            ST_PAY: if (last_pay) state <= ST_CSUM;
            ST_CSUM: if (fire) begin
               state       <= ST_IDLE;
               frame_cnt_q <= frame_cnt_q + 16'd1;
               req_hold    <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase

         if (rd_en) rd_cnt <= rd_cnt + 8'd1;

         unique case ({rd_en, fifo_push})
            2'b10:   out_cnt <= out_cnt + 1'b1;
            2'b01:   out_cnt <= out_cnt - 1'b1;
            default: ;
         endcase

         if (pay_fire) csum <= csum + sr[63:56];

         if (fifo_pop) begin
            sr      <= fifo_rdata;
            sr_cnt  <= 4'd8;
            pop_cnt <= pop_cnt + 8'd1;
         end else if (pay_fire) begin
            sr     <= {sr[55:0], 8'h00};
            sr_cnt <= sr_cnt - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_status_frame_reader.sv
// Bench for status_frame_reader: two instances (128 words, 1 word).
// Frames are checked against a byte-list model of the frame format.
module tb_status_frame_reader;
   import status_frame_reader_pkg::*;

   localparam int WC0   = 128;
   localparam int WC1   = 1;
   localparam int DEPTH = 4;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int tests = 0;
   int fails = 0;

   logic        req0 = 1'b0, req1 = 1'b0;
   logic        busy0, busy1, rd0, rd1;
   logic [6:0]  addr0, addr1;
   word_t       rdat0 = '0, rdat1 = '0;
   logic        vld0 = 1'b0, vld1 = 1'b0;
   logic [15:0] fcnt0, fcnt1;

   status_frame_reader_if tx0 ();
   status_frame_reader_if tx1 ();

   status_frame_reader #(
      .WORD_CNT(WC0), .HDR_WORD(16'hEB90), .FIFO_DEPTH(DEPTH)
   ) dut0 (
      .sys_clk(sys_clk), .rst_n(rst_n), .req(req0), .busy(busy0),
      .status_ram_addr(addr0), .status_ram_rd_en(rd0),
      .status_ram_data(rdat0), .status_ram_data_vld(vld0),
      .tx(tx0.master), .frame_cnt(fcnt0)
   );

   status_frame_reader #(
      .WORD_CNT(WC1), .HDR_WORD(16'hEB90), .FIFO_DEPTH(DEPTH)
   ) dut1 (
      .sys_clk(sys_clk), .rst_n(rst_n), .req(req1), .busy(busy1),
      .status_ram_addr(addr1), .status_ram_rd_en(rd1),
      .status_ram_data(rdat1), .status_ram_data_vld(vld1),
      .tx(tx1.master), .frame_cnt(fcnt1)
   );

   function automatic word_t ram_word(int n);
      logic [31:0] hi, lo;
      hi = 32'hA5A5_0000 + 32'(n);
      lo = 32'(n);
      return {hi, lo};
   endfunction

   // RAM models: data 2 clocks after rd_en, no reset.
   logic       p0_v = 1'b0, p1_v = 1'b0;
   logic [6:0] p0_a = '0, p1_a = '0;
   always @(posedge sys_clk) begin
      p0_v  <= rd0;
      p0_a  <= addr0;
      vld0  <= p0_v;
      rdat0 <= ram_word(int'(p0_a));
      p1_v  <= rd1;
      p1_a  <= addr1;
      vld1  <= p1_v;
      rdat1 <= ram_word(int'(p1_a));
   end

   bit rnd_ready = 1'b0;
   initial begin
      tx0.tx_ready = 1'b1;
      tx1.tx_ready = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         tx0.tx_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   logic [7:0] got0[$], got1[$];
   bit         gl0[$], gl1[$];
   int         bcyc0 = 0, bcyc1 = 0;
   int         hold_bad = 0, ovf = 0;
   int         rd1_cnt = 0, rd1_bad = 0;
   logic       pv0 = 1'b0, pl0 = 1'b0;
   logic [7:0] pd0 = '0;

   always @(negedge sys_clk) begin
      if (pv0 && !(tx0.tx_valid && tx0.tx_data == pd0 &&
                   tx0.tx_last == pl0)) hold_bad++;
      pv0 = rst_n && tx0.tx_valid && !tx0.tx_ready;
      pd0 = tx0.tx_data;
      pl0 = tx0.tx_last;
      if (tx0.tx_valid && tx0.tx_ready) begin
         got0.push_back(tx0.tx_data);
         gl0.push_back(tx0.tx_last);
      end
      if (tx1.tx_valid && tx1.tx_ready) begin
         got1.push_back(tx1.tx_data);
         gl1.push_back(tx1.tx_last);
      end
      if (busy0) bcyc0++;
      if (busy1) bcyc1++;
      if (dut0.fifo_push && dut0.fifo_full) ovf++;
      if (dut0.fifo_cnt > DEPTH) ovf++;
      if (rd1) begin
         rd1_cnt++;
         if (addr1 != 7'd0) rd1_bad++;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] exp_q[$];

   task automatic build_frame(int wc, logic [15:0] seq);
      int    sum;
      word_t w;
      exp_q = {};
      exp_q.push_back(8'hEB);
      exp_q.push_back(8'h90);
      exp_q.push_back(seq[15:8]);
      exp_q.push_back(seq[7:0]);
      sum = 0;
      for (int n = 0; n < wc; n++) begin
         w = ram_word(n);
         for (int b = 7; b >= 0; b--) begin
            exp_q.push_back(w[b*8 +: 8]);
            sum += int'(w[b*8 +: 8]);
         end
      end
      exp_q.push_back(8'(sum % 256));
   endtask

   task automatic cmp_frame(string tag, input logic [7:0] got[$],
                            input bit gl[$], int wc, logic [15:0] seq);
      int bad, nlast, lpos;
      build_frame(wc, seq);
      check({tag, ":len"}, 64'(got.size()), 64'(wc * 8 + FRAME_OVH));
      bad = 0;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (got[i] !== exp_q[i]) bad++;
      check({tag, ":bytes_bad"}, 64'(bad), 64'd0);
      nlast = 0;
      lpos  = -1;
      for (int i = 0; i < gl.size(); i++)
         if (gl[i]) begin
            nlast++;
            lpos = i;
         end
      check({tag, ":last_cnt"}, 64'(nlast), 64'd1);
      check({tag, ":last_pos"}, 64'(lpos), 64'(exp_q.size() - 1));
      if (got.size() >= 4)
         check({tag, ":hdr_seq"}, {got[0], got[1], got[2], got[3]},
               {8'hEB, 8'h90, seq});
      if (got.size() > 0)
         check({tag, ":csum"}, got[got.size()-1], exp_q[exp_q.size()-1]);
   endtask

   task automatic pulse(int which);
      if (which == 0) req0 = 1'b1; else req1 = 1'b1;
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic wait_idle(int which, int budget, string tag);
      int n;
      n = 0;
      while ((which == 0 ? busy0 : busy1) && n < budget) begin
         tick();
         n++;
      end
      check({tag, ":timeout"}, (which == 0 ? busy0 : busy1), 1'b0);
      repeat (2) tick();
   endtask

   task automatic clr();
      got0 = {}; gl0 = {}; got1 = {}; gl1 = {};
      bcyc0 = 0; bcyc1 = 0;
   endtask

   initial begin
      int n;
      repeat (3) tick();
      check("rst:busy", busy0, 1'b0);
      check("rst:valid", tx0.tx_valid, 1'b0);
      check("rst:last", tx0.tx_last, 1'b0);
      check("rst:data", tx0.tx_data, 8'h00);
      check("rst:rd_en", rd0, 1'b0);
      check("rst:frame_cnt", fcnt0, 16'h0);
      rst_n = 1'b1;
      repeat (2) tick();

      // full frame, sink always ready
      clr();
      pulse(0);
      check("t1:lat_valid", tx0.tx_valid, 1'b1);
      check("t1:lat_data", tx0.tx_data, 8'hEB);
      check("t1:busy", busy0, 1'b1);
      wait_idle(0, 5000, "t1");
      cmp_frame("t1", got0, gl0, WC0, 16'd0);
      check("t1:frame_cnt", fcnt0, 16'd1);
      check("t1:busy_cycles", 64'(bcyc0), 64'(8 * WC0 + FRAME_OVH));

      // random back-pressure
      clr();
      rnd_ready = 1'b1;
      pulse(0);
      wait_idle(0, 20000, "t2");
      rnd_ready = 1'b0;
      cmp_frame("t2", got0, gl0, WC0, 16'd1);
      check("t2:frame_cnt", fcnt0, 16'd2);

      // req while busy, and req in the cycle busy drops
      clr();
      pulse(0);
      repeat (20) tick();
      pulse(0);
      n = 0;
      while (busy0 && n < 5000) begin
         tick();
         n++;
      end
      check("t3:drop_timeout", busy0, 1'b0);
      cmp_frame("t3a", got0, gl0, WC0, 16'd2);
      check("t3a:frame_cnt", fcnt0, 16'd3);
      clr();
      pulse(0);
      check("t3:req_at_drop_ignored", busy0, 1'b0);
      pulse(0);
      check("t3:req_next_accepted", busy0, 1'b1);
      wait_idle(0, 5000, "t3b");
      cmp_frame("t3b", got0, gl0, WC0, 16'd3);
      check("t3b:frame_cnt", fcnt0, 16'd4);

      // reset in the middle of the payload
      clr();
      pulse(0);
      n = 0;
      while (got0.size() < 304 && n < 5000) begin
         tick();
         n++;
      end
      check("t4:reached_byte300", 64'(got0.size()), 64'd304);
      rst_n = 1'b0;
      #1;
      check("t4:valid", tx0.tx_valid, 1'b0);
      check("t4:data", tx0.tx_data, 8'h00);
      check("t4:busy", busy0, 1'b0);
      check("t4:rd_en", rd0, 1'b0);
      check("t4:frame_cnt", fcnt0, 16'd0);
      n = 0;
      foreach (gl0[i]) if (gl0[i]) n++;
      check("t4:no_last", 64'(n), 64'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("t4:fifo_empty", dut0.fifo_cnt, 0);
      clr();
      pulse(0);
      wait_idle(0, 5000, "t4b");
      cmp_frame("t4b", got0, gl0, WC0, 16'd0);
      check("t4b:frame_cnt", fcnt0, 16'd1);

      // single-word frame
      clr();
      rd1_cnt = 0;
      rd1_bad = 0;
      pulse(1);
      wait_idle(1, 500, "t6");
      cmp_frame("t6", got1, gl1, WC1, 16'd0);
      check("t6:rd_cnt", 64'(rd1_cnt), 64'd1);
      check("t6:rd_addr_bad", 64'(rd1_bad), 64'd0);
      check("t6:busy_cycles", 64'(bcyc1), 64'(8 * WC1 + FRAME_OVH));
      check("t6:frame_cnt", fcnt1, 16'd1);

      // sequence wrap
      force dut1.frame_cnt_q = 16'hFFFF;
      tick();
      release dut1.frame_cnt_q;
      tick();
      check("t5:preset", fcnt1, 16'hFFFF);
      clr();
      pulse(1);
      wait_idle(1, 500, "t5");
      cmp_frame("t5", got1, gl1, WC1, 16'hFFFF);
      check("t5:wrap", fcnt1, 16'h0000);

      check("fifo_overflow", 64'(ovf), 64'd0);
      check("hold_stable", 64'(hold_bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
